// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner: synchroniser, stable-sample debouncer and
// press / release / long-press / auto-repeat pulse generator on a shared sample tick.
module btn_debounce_multi #(
   parameter int N_CH           = 4,
   parameter int CLK_HZ         = 125000000,
   parameter int SAMPLE_HZ      = 1000,
   parameter int STABLE_CNT     = 8,
   parameter int LONG_SAMPLES   = 1000,
   parameter int REPEAT_SAMPLES = 100,
   parameter int ACTIVE_LOW     = 0
) (
   input  logic              CLK,
   input  logic              rstn,
   input  logic [N_CH-1:0]   btn_in,
   output logic [N_CH-1:0]   btn_level,
   output logic [N_CH-1:0]   press,
   // release and repeat are reserved words, hence the _pulse suffix
   output logic [N_CH-1:0]   release_pulse,
   output logic [N_CH-1:0]   long_press,
   output logic [N_CH-1:0]   repeat_pulse,
   output logic [2*N_CH-1:0] dbg_state
);

   localparam int DIV      = CLK_HZ / SAMPLE_HZ;
   localparam int PW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IW       = $clog2(STABLE_CNT + 1);
   localparam int HOLD_MAX = (LONG_SAMPLES > REPEAT_SAMPLES) ? LONG_SAMPLES : REPEAT_SAMPLES;
   localparam int HW       = $clog2(HOLD_MAX + 1);

   localparam logic [PW-1:0] PRE_LAST    = PW'(DIV - 1);
   localparam logic [IW-1:0] STABLE_LAST = IW'(STABLE_CNT - 1);
   localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_SAMPLES - 1);
   localparam logic [HW-1:0] REP_LAST    = HW'((REPEAT_SAMPLES > 0) ? REPEAT_SAMPLES - 1 : 0);
   localparam logic          INACTIVE    = (ACTIVE_LOW != 0);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } state_t;

   logic [N_CH-1:0] sync_s1;
   logic [N_CH-1:0] sync_s2;
   logic [PW-1:0]   pre_cnt;
   logic            tick;

   // Synchroniser resets to the idle raw level so no phantom press follows reset.
   always_ff @(posedge CLK) begin
      if (!rstn) begin
         sync_s1 <= {N_CH{INACTIVE}};
         sync_s2 <= {N_CH{INACTIVE}};
      end else begin
         sync_s1 <= btn_in;
         sync_s2 <= sync_s1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!rstn) begin
         pre_cnt <= '0;
      end else if (pre_cnt == PRE_LAST) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PW'(1);
      end
   end

   assign tick = (pre_cnt == PRE_LAST);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      state_t        state;
      logic [IW-1:0] icnt;
      logic [HW-1:0] hold;
      logic          lvl;
      logic          p_press;
      logic          p_rel;
      logic          p_long;
      logic          p_rep;
      logic          sample;
      logic          accept;

      assign sample = sync_s2[i] ^ INACTIVE;
      // One accepted level change per tick; its direction is implied by the current level.
      assign accept = tick && (sample != lvl) && (icnt == STABLE_LAST);

      always_ff @(posedge CLK) begin
         if (!rstn) begin
            state   <= ST_IDLE;
            icnt    <= '0;
            hold    <= '0;
            lvl     <= 1'b0;
            p_press <= 1'b0;
            p_rel   <= 1'b0;
            p_long  <= 1'b0;
            p_rep   <= 1'b0;
         end else begin
            p_press <= 1'b0;
            p_rel   <= 1'b0;
            p_long  <= 1'b0;
            p_rep   <= 1'b0;
            if (tick) begin
               if (sample == lvl) begin
                  icnt <= '0;
               end else if (accept) begin
                  icnt <= '0;
                  lvl  <= ~lvl;
               end else begin
                  icnt <= icnt + IW'(1);
               end

               case (state)
                  ST_IDLE: begin
                     if (accept) begin
                        state   <= ST_PRESSED;
                        p_press <= 1'b1;
                        hold    <= '0;
                     end
                  end
                  ST_PRESSED: begin
                     if (accept) begin
                        state <= ST_IDLE;
                        p_rel <= 1'b1;
                        hold  <= '0;
                     end else if (hold == LONG_LAST) begin
                        state  <= ST_HELD;
                        p_long <= 1'b1;
                        hold   <= '0;
                     end else begin
                        hold <= hold + HW'(1);
                     end
                  end
                  ST_HELD: begin
                     if (accept) begin
                        state <= ST_IDLE;
                        p_rel <= 1'b1;
                        hold  <= '0;
                     end else if (REPEAT_SAMPLES > 0) begin
                        if (hold == REP_LAST) begin
                           p_rep <= 1'b1;
                           hold  <= '0;
                        end else begin
                           hold <= hold + HW'(1);
                        end
                     end
                  end
                  default: begin
                     state <= ST_IDLE;
                     hold  <= '0;
                  end
               endcase
            end
         end
      end

      assign btn_level[i]         = lvl;
      assign press[i]             = p_press;
      assign release_pulse[i]     = p_rel;
      assign long_press[i]        = p_long;
      assign repeat_pulse[i]      = p_rep;
      assign dbg_state[2*i +: 2]  = state;
   end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Bench for btn_debounce_multi: active-high instance with repeat, active-low instance without,
// driven from a cycle-stamped stimulus table and checked every cycle against an event table.
module tb_btn_debounce_multi;

   localparam int N_EV = 14;
   localparam int N_ST = 17;

   typedef struct {
      int         cyc;
      int         dut;
      logic [1:0] press;
      logic [1:0] rel;
      logic [1:0] lng;
      logic [1:0] rpt;
   } ev_t;

   typedef struct {
      int         cyc;
      logic [1:0] a;
      logic [1:0] b;
   } stim_t;

   ev_t   ev_tab[N_EV];
   stim_t st_tab[N_ST];

   logic       CLK  = 1'b0;
   logic       rstn = 1'b0;
   logic [1:0] btn_a = 2'b11;
   logic [1:0] btn_b = 2'b11;
   logic [1:0] lvl_a, prs_a, rel_a, lng_a, rpt_a;
   logic [1:0] lvl_b, prs_b, rel_b, lng_b, rpt_b;
   logic [3:0] dbg_a, dbg_b;

   int cyc   = 0;
   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   // cyc == j while the outputs produced by the j-th edge after the last reset edge are visible
   always @(posedge CLK) begin
      if (!rstn) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   btn_debounce_multi #(
      .N_CH(2), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE_CNT(3),
      .LONG_SAMPLES(5), .REPEAT_SAMPLES(2), .ACTIVE_LOW(0)
   ) dut_a (
      .CLK(CLK), .rstn(rstn), .btn_in(btn_a), .btn_level(lvl_a), .press(prs_a),
      .release_pulse(rel_a), .long_press(lng_a), .repeat_pulse(rpt_a), .dbg_state(dbg_a)
   );

   btn_debounce_multi #(
      .N_CH(2), .CLK_HZ(1000), .SAMPLE_HZ(100), .STABLE_CNT(3),
      .LONG_SAMPLES(5), .REPEAT_SAMPLES(0), .ACTIVE_LOW(1)
   ) dut_b (
      .CLK(CLK), .rstn(rstn), .btn_in(btn_b), .btn_level(lvl_b), .press(prs_b),
      .release_pulse(rel_b), .long_press(lng_b), .repeat_pulse(rpt_b), .dbg_state(dbg_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_pulses(input int c, input int d);
      logic [7:0] r;
      r = '0;
      for (int k = 0; k < N_EV; k++) begin
         if (ev_tab[k].cyc == c && ev_tab[k].dut == d)
            r = r | {ev_tab[k].press, ev_tab[k].rel, ev_tab[k].lng, ev_tab[k].rpt};
      end
      return r;
   endfunction

   initial begin
      logic [7:0] pa, pb;
      logic [1:0] exp_lvl_a, exp_lvl_b;
      int         si;
      int         found;

      // Expected pulses: cycle, dut (0 = active-high/repeat, 1 = active-low/no repeat), press, rel, long, rpt
      ev_tab[0]  = '{30,  0, 2'b11, 2'b00, 2'b00, 2'b00};
      ev_tab[1]  = '{80,  0, 2'b00, 2'b00, 2'b11, 2'b00};
      ev_tab[2]  = '{100, 0, 2'b00, 2'b00, 2'b00, 2'b11};
      ev_tab[3]  = '{120, 0, 2'b00, 2'b00, 2'b00, 2'b11};
      ev_tab[4]  = '{130, 0, 2'b00, 2'b10, 2'b00, 2'b00};
      ev_tab[5]  = '{140, 0, 2'b00, 2'b00, 2'b00, 2'b01};
      ev_tab[6]  = '{160, 0, 2'b00, 2'b01, 2'b00, 2'b00};
      ev_tab[7]  = '{230, 0, 2'b01, 2'b00, 2'b00, 2'b00};
      ev_tab[8]  = '{280, 0, 2'b00, 2'b01, 2'b00, 2'b00};
      ev_tab[9]  = '{560, 0, 2'b01, 2'b00, 2'b00, 2'b00};
      ev_tab[10] = '{600, 0, 2'b00, 2'b01, 2'b00, 2'b00};
      ev_tab[11] = '{230, 1, 2'b01, 2'b00, 2'b00, 2'b00};
      ev_tab[12] = '{280, 1, 2'b00, 2'b00, 2'b01, 2'b00};
      ev_tab[13] = '{430, 1, 2'b00, 2'b01, 2'b00, 2'b00};

      // Button values applied right after the edge of the given cycle
      st_tab[0]  = '{105, 2'b01, 2'b11};
      st_tab[1]  = '{135, 2'b00, 2'b11};
      st_tab[2]  = '{205, 2'b01, 2'b10};
      st_tab[3]  = '{255, 2'b00, 2'b10};
      st_tab[4]  = '{305, 2'b10, 2'b10};
      st_tab[5]  = '{320, 2'b00, 2'b10};
      st_tab[6]  = '{335, 2'b10, 2'b10};
      st_tab[7]  = '{350, 2'b00, 2'b10};
      st_tab[8]  = '{365, 2'b10, 2'b10};
      st_tab[9]  = '{380, 2'b00, 2'b10};
      st_tab[10] = '{395, 2'b10, 2'b10};
      st_tab[11] = '{405, 2'b10, 2'b11};
      st_tab[12] = '{410, 2'b00, 2'b11};
      st_tab[13] = '{505, 2'b01, 2'b11};
      st_tab[14] = '{525, 2'b00, 2'b11};
      st_tab[15] = '{530, 2'b01, 2'b11};
      st_tab[16] = '{575, 2'b00, 2'b11};

      // Reset held for three edges with both buttons of the active-high unit pressed
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         check("reset_out_a", 32'({lvl_a, prs_a, rel_a, lng_a, rpt_a}), 32'd0);
         check("reset_out_b", 32'({lvl_b, prs_b, rel_b, lng_b, rpt_b}), 32'd0);
         check("reset_state", 32'({dbg_a, dbg_b}), 32'd0);
      end
      rstn = 1'b1;

      exp_lvl_a = 2'b00;
      exp_lvl_b = 2'b00;
      si = 0;
      while (cyc < 650) begin
         @(negedge CLK);
         pa = exp_pulses(cyc, 0);
         pb = exp_pulses(cyc, 1);
         exp_lvl_a = (exp_lvl_a | pa[7:6]) & ~pa[5:4];
         exp_lvl_b = (exp_lvl_b | pb[7:6]) & ~pb[5:4];
         check("timeline_a", 32'({lvl_a, prs_a, rel_a, lng_a, rpt_a}), 32'({exp_lvl_a, pa}));
         check("timeline_b", 32'({lvl_b, prs_b, rel_b, lng_b, rpt_b}), 32'({exp_lvl_b, pb}));
         if (si < N_ST && st_tab[si].cyc == cyc) begin
            btn_a = st_tab[si].a;
            btn_b = st_tab[si].b;
            si++;
         end
      end

      // Reset in the middle of a hold: no release, then a fresh press after three ticks
      btn_a = 2'b01;
      found = -1;
      for (int k = 0; k < 60 && found < 0; k++) begin
         @(negedge CLK);
         if (prs_a[0]) found = cyc;
      end
      check("hold_press_cyc", 32'(found), 32'd680);
      while (cyc < 705) @(negedge CLK);
      check("hold_level", 32'({lvl_a, lng_a, rpt_a}), 32'b010000);
      rstn = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         check("midhold_reset_a", 32'({lvl_a, prs_a, rel_a, lng_a, rpt_a}), 32'd0);
      end
      rstn = 1'b1;
      while (cyc < 40) begin
         @(negedge CLK);
         check("rehold_a", 32'({lvl_a, prs_a, rel_a, lng_a, rpt_a}),
               32'({(cyc >= 30) ? 2'b01 : 2'b00, (cyc == 30) ? 2'b01 : 2'b00, 6'b0}));
         check("rehold_b", 32'({lvl_b, prs_b, rel_b, lng_b, rpt_b}), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/btn_debounce_multi.md
# btn_debounce_multi

Parametrised multi-channel push-button conditioner: synchronises N asynchronous switch inputs, debounces each with a stable-sample integrator on a shared sample tick, and emits the debounced level plus one-clock press, release, long-press and auto-repeat pulses per channel. It sits between board buttons and control logic, replacing single-channel rising-edge-only debouncers.

## Interface
- N_CH, 4, number of independent button channels (≥1)
- CLK_HZ, 125000000, CLK frequency in Hz
- SAMPLE_HZ, 1000, debounce sample rate; DIV = CLK_HZ/SAMPLE_HZ, integer, ≥2
- STABLE_CNT, 8, consecutive differing samples required to accept a level change (≥1)
- LONG_SAMPLES, 1000, samples held after accepted press before long_press fires (≥1)
- REPEAT_SAMPLES, 100, samples between repeat pulses after long_press; 0 disables repeat
- ACTIVE_LOW, 0, 1 = pressed button drives btn_in low

- CLK  input  1  system clock
- rstn  input  1  reset, synchronous, active-low
- btn_in  input  N_CH  raw asynchronous button inputs
- btn_level  output  N_CH  debounced logical level, 1 = pressed
- press  output  N_CH  one-clock pulse on accepted press
- release  output  N_CH  one-clock pulse on accepted release
- long_press  output  N_CH  one-clock pulse when held LONG_SAMPLES samples
- repeat  output  N_CH  one-clock pulse every REPEAT_SAMPLES samples after long_press while held

## Operation
- Synchroniser: two FFs per channel, every CLK; input XORed with ACTIVE_LOW after synchronisation so logic is active-high.
- Prescaler: shared counter 0..DIV-1; tick asserted for one CLK when counter = DIV-1, then wraps to 0. Width $clog2(DIV).
- Integrator per channel, updated only on tick: sample ≠ btn_level → cnt+1; sample = btn_level → cnt cleared. When cnt+1 = STABLE_CNT: btn_level toggles, cnt cleared. Any glitch back to current level restarts the count.
- Per-channel FSM, advances only on tick except reset:
  - IDLE: btn_level 0. Accepted press → PRESSED, press pulse, hold counter cleared.
  - PRESSED: hold counter +1 per tick; reaching LONG_SAMPLES → HELD, long_press pulse, hold counter cleared.
  - HELD: if REPEAT_SAMPLES>0, hold counter +1 per tick; reaching REPEAT_SAMPLES → repeat pulse, counter cleared, stay HELD. REPEAT_SAMPLES=0: no counting, no repeat.
  - Accepted release in PRESSED or HELD → IDLE, release pulse; pending long/repeat cancelled, no pulse in that cycle.
- Channels fully independent; any combination of pulses on different channels in the same cycle is legal.
- Counters saturate-free: widths $clog2(max+1) of their terminal value; no wrap possible since each clears at terminal.

## Timing
- All outputs registered. Reset (rstn=0 at CLK edge): btn_level, press, release, long_press, repeat = 0; prescaler, integrators, hold counters = 0; FSMs IDLE; synchroniser FFs = inactive raw level (ACTIVE_LOW).
- press/release assert in the same CLK that btn_level changes, i.e. one CLK after the accepting tick; pulses last exactly one CLK.
- Latency clean edge → btn_level: 2 CLK sync + STABLE_CNT ticks (first tick after sync may arrive up to DIV-1 CLK later) + 1 CLK.
- long_press: exactly LONG_SAMPLES ticks after press pulse tick; first repeat REPEAT_SAMPLES ticks after long_press.
- Press and release on the same channel never occur in the same cycle (one accept per tick).
- Reset mid-hold: no release pulse generated; after reset a still-held button is re-accepted as a fresh press after STABLE_CNT ticks.
- Prescaler runs continuously regardless of button activity.

## Test plan
Bench params: N_CH=2, CLK_HZ=1000, SAMPLE_HZ=100 (DIV=10), STABLE_CNT=3, LONG_SAMPLES=5, REPEAT_SAMPLES=2, ACTIVE_LOW=0.
- Reset: rstn low 3 CLK with btn_in=2'b11 → all outputs 0 during and 1 CLK after; btn_level[0] rises only after 3 ticks post-reset.
- Clean press ch0 held 40 CLK then released → press pulse at 3rd tick + 1 CLK; long_press 5 ticks later; repeat after a further 2 ticks; release pulse 3 ticks after falling edge, no repeat after it.
- Bounce: ch1 toggled every 15 CLK (alternating samples) for 100 CLK → btn_level[1] stays 0, no pulses.
- Glitch: ch0 pressed, one-tick low glitch at tick 2 → integrator restarts, press 3 ticks after glitch ends.
- Simultaneous: ch0 and ch1 pressed same CLK → press=2'b11 in one cycle; release ch1 during ch0 HELD → only release[1], ch0 repeats continue.
- ACTIVE_LOW=1, REPEAT_SAMPLES=0: idle btn_in=1 → level 0; hold low 20 ticks → press, long_press once, no repeat pulses.
